// File: rtl/sense_chain_pkg.sv
// Shared constants, stage payload type and load helper for the sense_chain
// register pipeline.
package sense_chain_pkg;

  localparam int unsigned DEFAULT_WIDTH        = 14;
  localparam int unsigned DEFAULT_CHAIN_LENGTH = 4;
  localparam int unsigned MAX_CHAIN_LENGTH     = 64;

  // Stage payload at the default width; sense_stage declares the same shape at its own WIDTH.
  typedef struct packed {
    logic                     ena;
    logic [DEFAULT_WIDTH-1:0] data;
  } stage_t;

  // A stage may take new data when it is empty or its current item is leaving.
  function automatic logic can_load(input logic ena, input logic move);
    return !ena || move;
  endfunction

endpackage

// File: rtl/sense_stage.sv
// One pipeline stage: a valid/data register pair that loads from its source
// when it is empty or moving, and moves when its successor can accept.
module sense_stage
  import sense_chain_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             src_ena,
  input  logic [WIDTH-1:0] src_data,
  input  logic             succ_rdy,
  output logic             move_c,
  output logic             ena,
  output logic [WIDTH-1:0] data
);

  typedef struct packed {
    logic             ena;
    logic [WIDTH-1:0] data;
  } stage_w_t;

  stage_w_t         stage_d;
  logic             ena_q;
  logic [WIDTH-1:0] data_q;
  logic             load_c;

  // Load wins over move so a stage that hands off and refills stays valid.
  always_comb begin
    move_c       = ena_q & succ_rdy;
    load_c       = can_load(ena_q, move_c) & src_ena;
    stage_d.ena  = ena_q;
    stage_d.data = data_q;
    if (flush) begin
      stage_d.ena = 1'b0;
    end else if (load_c) begin
      stage_d.ena  = 1'b1;
      stage_d.data = src_data;
    end else if (move_c) begin
      stage_d.ena = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ena_q <= 1'b0;
    end else begin
      ena_q <= stage_d.ena;
    end
  end

  // Data is qualified by ena_q, so it carries no reset.
  always_ff @(posedge clk) begin
    data_q <= stage_d.data;
  end

  assign ena  = ena_q;
  assign data = data_q;

endmodule

// File: rtl/sense_chain.sv
// Elastic register chain of CHAIN_LENGTH stages with valid/ready handshakes,
// bubble collapsing, synchronous flush and a registered occupancy count.
module sense_chain
  import sense_chain_pkg::*;
#(
  parameter int unsigned WIDTH        = DEFAULT_WIDTH,
  parameter int unsigned CHAIN_LENGTH = DEFAULT_CHAIN_LENGTH,
  parameter int unsigned CNT_W        = $clog2(CHAIN_LENGTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_ena,
  input  logic [WIDTH-1:0]        in_data,
  output logic                    in_rdy,
  output logic                    out_ena,
  output logic [WIDTH-1:0]        out_data,
  input  logic                    out_rdy,
  output logic [CHAIN_LENGTH-1:0] stage_ena,
  output logic [CNT_W-1:0]        count
);

  logic [CHAIN_LENGTH-1:0] stage_ena_w;
  logic [CHAIN_LENGTH-1:0] move_w;
  logic [CHAIN_LENGTH-1:0] succ_rdy_w;
  logic [CHAIN_LENGTH-1:0] src_ena_w;
  logic [WIDTH-1:0]        stage_data_w [CHAIN_LENGTH];
  logic [WIDTH-1:0]        src_data_w   [CHAIN_LENGTH];

  logic             in_xfer_c;
  logic             out_xfer_c;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  for (genvar i = 0; i < int'(CHAIN_LENGTH); i++) begin : g_stage
    // A successor can accept if any later stage is empty or the output drains.
    if (i == int'(CHAIN_LENGTH) - 1) begin : g_tail
      assign succ_rdy_w[i] = ~flush & out_rdy;
    end else begin : g_inner
      assign succ_rdy_w[i] = ~flush & (out_rdy | ~(&stage_ena_w[CHAIN_LENGTH-1:i+1]));
    end

    if (i == 0) begin : g_head
      assign src_ena_w[i]  = in_ena & ~flush;
      assign src_data_w[i] = in_data;
    end else begin : g_body
      assign src_ena_w[i]  = move_w[i-1];
      assign src_data_w[i] = stage_data_w[i-1];
    end

    sense_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .src_ena  (src_ena_w[i]),
      .src_data (src_data_w[i]),
      .succ_rdy (succ_rdy_w[i]),
      .move_c   (move_w[i]),
      .ena      (stage_ena_w[i]),
      .data     (stage_data_w[i])
    );
  end

  assign in_rdy     = ~flush & can_load(stage_ena_w[0], move_w[0]);
  assign in_xfer_c  = in_ena & in_rdy;
  assign out_xfer_c = move_w[CHAIN_LENGTH-1];

  // Occupancy tracks the transfers, so it always equals the number of set valids.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      count_d = count_q + CNT_W'(in_xfer_c) - CNT_W'(out_xfer_c);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign out_ena   = stage_ena_w[CHAIN_LENGTH-1];
  assign out_data  = stage_data_w[CHAIN_LENGTH-1];
  assign stage_ena = stage_ena_w;
  assign count     = count_q;

endmodule

// File: tb/tb_sense_chain.sv
// Scoreboard bench for sense_chain: a default-size chain under directed and
// random traffic, and a 1-stage 50-bit chain under random traffic.
module tb_sense_chain;

  localparam int unsigned A_LEN = 4;
  localparam int unsigned A_W   = 14;
  localparam int unsigned B_W   = 50;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             a_flush = 1'b0, a_in_ena = 1'b0, a_out_rdy = 1'b0;
  logic [A_W-1:0]   a_in_data = '0;
  logic             a_in_rdy, a_out_ena;
  logic [A_W-1:0]   a_out_data;
  logic [A_LEN-1:0] a_stage_ena;
  logic [2:0]       a_count;

  logic             b_flush = 1'b0, b_in_ena = 1'b0, b_out_rdy = 1'b0;
  logic [B_W-1:0]   b_in_data = '0;
  logic             b_in_rdy, b_out_ena;
  logic [B_W-1:0]   b_out_data;
  logic [0:0]       b_stage_ena;
  logic [0:0]       b_count;

  sense_chain dut_a (
    .clk(clk), .rst(rst), .flush(a_flush), .in_ena(a_in_ena), .in_data(a_in_data),
    .in_rdy(a_in_rdy), .out_ena(a_out_ena), .out_data(a_out_data), .out_rdy(a_out_rdy),
    .stage_ena(a_stage_ena), .count(a_count)
  );

  sense_chain #(.WIDTH(B_W), .CHAIN_LENGTH(1)) dut_b (
    .clk(clk), .rst(rst), .flush(b_flush), .in_ena(b_in_ena), .in_data(b_in_data),
    .in_rdy(b_in_rdy), .out_ena(b_out_ena), .out_data(b_out_data), .out_rdy(b_out_rdy),
    .stage_ena(b_stage_ena), .count(b_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Reference model: the chain is an ordered collection of accepted items.
  logic [A_W-1:0] a_model[$];
  logic [B_W-1:0] b_model[$];
  logic           a_exp_rdy, b_exp_rdy;
  logic [A_W-1:0] a_exp_data;
  logic [B_W-1:0] b_exp_data;

  always @(negedge clk) begin
    if (rst) begin
      a_model.delete();
    end else begin
      check("a_count", 64'(a_count), 64'(a_model.size()));
      check("a_popcount", 64'($countones(a_stage_ena)), 64'(a_model.size()));
      a_exp_rdy = !a_flush && (a_model.size() < int'(A_LEN) || a_out_rdy);
      check("a_in_rdy", 64'(a_in_rdy), 64'(a_exp_rdy));
      if (a_out_ena && a_out_rdy && !a_flush) begin
        if (a_model.size() == 0) check("a_out_spurious", 64'(a_out_ena), 64'(0));
        else begin
          a_exp_data = a_model.pop_front();
          check("a_out_data", 64'(a_out_data), 64'(a_exp_data));
        end
      end
      if (a_exp_rdy && a_in_ena) a_model.push_back(a_in_data);
      if (a_flush) a_model.delete();
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      b_model.delete();
    end else begin
      check("b_count", 64'(b_count), 64'(b_model.size()));
      check("b_popcount", 64'($countones(b_stage_ena)), 64'(b_model.size()));
      check("b_out_ena", 64'(b_out_ena), 64'(b_model.size() != 0));
      b_exp_rdy = !b_flush && (b_model.size() < 1 || b_out_rdy);
      check("b_in_rdy", 64'(b_in_rdy), 64'(b_exp_rdy));
      if (b_out_ena && b_out_rdy && !b_flush && b_model.size() != 0) begin
        b_exp_data = b_model.pop_front();
        check("b_out_data", 64'(b_out_data), 64'(b_exp_data));
      end
      if (b_exp_rdy && b_in_ena) b_model.push_back(b_in_data);
      if (b_flush) b_model.delete();
    end
  end

  task automatic push_a(input logic [A_W-1:0] v);
    bit done = 1'b0;
    @(posedge clk); #1;
    a_in_ena  = 1'b1;
    a_in_data = v;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (a_in_rdy) done = 1'b1;
    end
    if (!done) check("a_push_timeout", 64'(a_in_rdy), 64'(1));
    @(posedge clk); #1;
    a_in_ena = 1'b0;
  endtask

  task automatic wait_a_empty();
    bit done = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (a_count == 0 && a_model.size() == 0) done = 1'b1;
    end
    check("a_drain", 64'(a_count), 64'(0));
  endtask

  // Item accepted into an empty chain shows at the output in the fourth cycle after the accepting edge.
  task automatic latency_a(input logic [A_W-1:0] v);
    @(posedge clk); #1;
    a_out_rdy = 1'b1;
    a_in_ena  = 1'b1;
    a_in_data = v;
    @(negedge clk);
    check("lat_accept_rdy", 64'(a_in_rdy), 64'(1));
    @(posedge clk); #1;
    a_in_ena = 1'b0;
    for (int k = 1; k <= int'(A_LEN); k++) begin
      @(negedge clk);
      check("lat_count", 64'(a_count), 64'(1));
      check("lat_out_ena", 64'(a_out_ena), 64'(k == int'(A_LEN)));
      if (k == int'(A_LEN)) check("lat_out_data", 64'(a_out_data), 64'(v));
    end
    @(negedge clk);
    check("lat_drained", 64'(a_count), 64'(0));
  endtask

  initial begin
    int rdy_pct, in_pct;

    repeat (3) @(posedge clk);
    #2;
    check("rst_out_ena", 64'(a_out_ena), 64'(0));
    check("rst_stage_ena", 64'(a_stage_ena), 64'(0));
    check("rst_count", 64'(a_count), 64'(0));
    check("rst_b_out_ena", 64'(b_out_ena), 64'(0));
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    check("rel_a_in_rdy", 64'(a_in_rdy), 64'(1));
    check("rel_b_in_rdy", 64'(b_in_rdy), 64'(1));

    latency_a(14'h1234);

    // Back-pressure: four items fill the chain, the fifth waits.
    @(posedge clk); #1;
    a_out_rdy = 1'b0;
    for (int k = 1; k <= 4; k++) push_a(A_W'(5 * k));
    @(posedge clk); #1;
    a_in_ena  = 1'b1;
    a_in_data = A_W'(25);
    @(negedge clk);
    check("full_in_rdy", 64'(a_in_rdy), 64'(0));
    check("full_count", 64'(a_count), 64'(4));
    check("full_stage_ena", 64'(a_stage_ena), 64'(4'hF));
    repeat (3) begin
      @(negedge clk);
      check("full_hold_data", 64'(a_out_data), 64'(5));
    end
    @(posedge clk); #1;
    a_out_rdy = 1'b1;
    @(negedge clk);
    check("full_release_rdy", 64'(a_in_rdy), 64'(1));
    @(posedge clk); #1;
    a_in_ena = 1'b0;
    wait_a_empty();

    // Full chain streaming: one in and one out every cycle.
    @(posedge clk); #1;
    a_out_rdy = 1'b0;
    for (int k = 1; k <= 4; k++) push_a(A_W'(3 * k));
    @(posedge clk); #1;
    a_out_rdy = 1'b1;
    a_in_ena  = 1'b1;
    a_in_data = A_W'(15);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("stream_in_rdy", 64'(a_in_rdy), 64'(1));
      check("stream_count", 64'(a_count), 64'(4));
      check("stream_out_ena", 64'(a_out_ena), 64'(1));
      @(posedge clk); #1;
      a_in_data = A_W'(15 + 3 * (k + 1));
    end
    a_in_ena = 1'b0;
    wait_a_empty();

    // Flush beats a simultaneous input offer.
    @(posedge clk); #1;
    a_out_rdy = 1'b0;
    push_a(A_W'(40));
    push_a(A_W'(41));
    @(posedge clk); #1;
    a_flush   = 1'b1;
    a_in_ena  = 1'b1;
    a_in_data = A_W'(77);
    @(negedge clk);
    check("flush_in_rdy", 64'(a_in_rdy), 64'(0));
    @(posedge clk); #1;
    a_flush  = 1'b0;
    a_in_ena = 1'b0;
    @(negedge clk);
    check("flush_count", 64'(a_count), 64'(0));
    check("flush_stage_ena", 64'(a_stage_ena), 64'(0));
    a_out_rdy = 1'b1;
    repeat (6) @(negedge clk);
    check("flush_no_accept", 64'(a_count), 64'(0));

    // Asynchronous reset between edges with items in flight.
    @(posedge clk); #1;
    a_out_rdy = 1'b0;
    for (int k = 0; k < 3; k++) push_a(A_W'(100 + k));
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("arst_out_ena", 64'(a_out_ena), 64'(0));
    check("arst_stage_ena", 64'(a_stage_ena), 64'(0));
    check("arst_count", 64'(a_count), 64'(0));
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    check("arst_rel_in_rdy", 64'(a_in_rdy), 64'(1));
    latency_a(14'h2abc);

    // Random traffic on both chains, alternating light and heavy back-pressure.
    for (int c = 0; c < 1000; c++) begin
      rdy_pct = ((c / 250) % 2 == 0) ? 80 : 30;
      in_pct  = ((c / 125) % 2 == 0) ? 70 : 40;
      @(posedge clk); #1;
      a_in_ena  = ($urandom_range(0, 99) < in_pct);
      a_in_data = A_W'($urandom);
      a_out_rdy = ($urandom_range(0, 99) < rdy_pct);
      a_flush   = ($urandom_range(0, 63) == 0);
      b_in_ena  = ($urandom_range(0, 99) < in_pct);
      b_in_data = B_W'({$urandom, $urandom});
      b_out_rdy = ($urandom_range(0, 99) < rdy_pct);
    end
    @(posedge clk); #1;
    a_in_ena  = 1'b0;
    a_flush   = 1'b0;
    a_out_rdy = 1'b1;
    b_in_ena  = 1'b0;
    b_out_rdy = 1'b1;
    repeat (10) @(negedge clk);
    check("a_final_model", 64'(a_model.size()), 64'(0));
    check("b_final_model", 64'(b_model.size()), 64'(0));
    check("b_final_count", 64'(b_count), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
